// File: rtl/gpu_host_port_arbiter.sv
// gpu_host_port_arbiter
//   Shares the single host read/write port of the GPU RAM among NUM_REQ bus
//   masters. At most one access is granted per clk, either round-robin or fixed
//   priority (lowest index wins). The granted access drives the RAM host port
//   from registers. Read returns are steered back to the issuing requester by a
//   tag pipeline that tracks the RAM read latency.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req/req_wr/req_16bit per-requester request, write flag, 16-bit write flag
//   req_addr/req_wdata  per-requester address and write data (unpacked)
//   gnt                 one-hot combinational grant
//   rd_valid/rd_data    one-hot registered read-return strobe and its data
//   write_ena_host, ena_host_16bit, addr_host_in, data_host_in  RAM host port
//   data_host_out       RAM host read data
module gpu_host_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int RD_LAT     = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_wr,
    input  logic [NUM_REQ-1:0] req_16bit,
    input  logic [19:0]        req_addr  [NUM_REQ],
    input  logic [15:0]        req_wdata [NUM_REQ],
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] rd_valid,
    output logic [15:0]        rd_data,
    output logic               write_ena_host,
    output logic               ena_host_16bit,
    output logic [19:0]        addr_host_in,
    output logic [15:0]        data_host_in,
    input  logic [15:0]        data_host_out
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDW-1:0]            ptr_q, ptr_d;
    logic [IDW-1:0]            grant_idx;
    logic                      grant_vld;
    int                        cand;

    logic                      wr_ena_q;
    logic                      b16_q;
    logic [19:0]               addr_q;
    logic [15:0]               wdata_q;

    // Read tags: valid bit and requester id, one stage per clk of RAM latency.
    // The tag at stage RD_LAT lines up with data_host_out for that read.
    logic [RD_LAT:0]           vld_pipe_q;
    logic [RD_LAT:0][IDW-1:0]  id_pipe_q;

    logic [NUM_REQ-1:0]        rd_valid_q;
    logic [15:0]               rd_data_q;

    // Arbitration: scan from ptr (round-robin) or from 0 (fixed priority),
    // first requesting index wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        gnt       = '0;
        if (!reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (FIXED_PRIO != 0) begin
                    cand = k;
                end else begin
                    cand = int'(ptr_q) + k;
                    if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                end
                if (!grant_vld && req[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = IDW'(cand);
                end
            end
            if (grant_vld) gnt[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            wr_ena_q   <= 1'b0;
            b16_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            vld_pipe_q <= '0;
            id_pipe_q  <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wr_ena_q <= grant_vld & req_wr[grant_idx];
            // Address/data/mode hold across idle cycles; only the strobe drops.
            if (grant_vld) begin
                addr_q  <= req_addr[grant_idx];
                wdata_q <= req_wdata[grant_idx];
                b16_q   <= req_16bit[grant_idx];
            end
            vld_pipe_q <= {vld_pipe_q[RD_LAT-1:0], grant_vld & ~req_wr[grant_idx]};
            id_pipe_q  <= {id_pipe_q[RD_LAT-1:0], grant_idx};

            rd_valid_q <= '0;
            if (vld_pipe_q[RD_LAT]) begin
                rd_valid_q[id_pipe_q[RD_LAT]] <= 1'b1;
                rd_data_q                     <= data_host_out;
            end
        end
    end

    assign write_ena_host = wr_ena_q;
    assign ena_host_16bit = b16_q;
    assign addr_host_in   = addr_q;
    assign data_host_in   = wdata_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;

endmodule

// File: tb/tb_gpu_host_port_arbiter.sv
// Directed bench for gpu_host_port_arbiter: round-robin instance with a small
// GPU RAM model (2-clk read latency, zero outside 0x00000..0x000FF), plus a
// fixed-priority instance for the priority check.
module tb_gpu_host_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    // Round-robin DUT
    logic [3:0]  req = '0, req_wr = '0, req_16bit = '0;
    logic [19:0] req_addr  [4];
    logic [15:0] req_wdata [4];
    logic [3:0]  gnt, rd_valid;
    logic [15:0] rd_data;
    logic        we, b16;
    logic [19:0] addr_h;
    logic [15:0] din_h;
    logic [15:0] dout_h = '0;

    // Fixed-priority DUT
    logic [3:0]  reqf = '0, zf = '0;
    logic [19:0] zaddr [4];
    logic [15:0] zdata [4];
    logic [3:0]  gntf, rdvf;
    logic [15:0] rddf, dinf, dout_f;
    logic        wef, b16f;
    logic [19:0] addrf;

    gpu_host_port_arbiter #(.NUM_REQ(4), .RD_LAT(2), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_16bit(req_16bit),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid),
        .rd_data(rd_data), .write_ena_host(we), .ena_host_16bit(b16),
        .addr_host_in(addr_h), .data_host_in(din_h), .data_host_out(dout_h));

    gpu_host_port_arbiter #(.NUM_REQ(4), .RD_LAT(2), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset), .req(reqf), .req_wr(zf), .req_16bit(zf),
        .req_addr(zaddr), .req_wdata(zdata), .gnt(gntf), .rd_valid(rdvf),
        .rd_data(rddf), .write_ena_host(wef), .ena_host_16bit(b16f),
        .addr_host_in(addrf), .data_host_in(dinf), .data_host_out(dout_f));

    assign dout_f = 16'h0;

    // RAM model: address seen in cycle T+1, data on data_host_out in T+3.
    logic [15:0] mem [256];
    logic [15:0] ram_s1 = '0;
    always @(posedge clk) begin
        if (we && addr_h < 20'h100) begin
            if (b16) mem[addr_h[7:0]] <= din_h;
            else     mem[addr_h[7:0]][7:0] <= din_h[7:0];
        end
        ram_s1 <= (addr_h < 20'h100) ? mem[addr_h[7:0]] : 16'h0;
        dout_h <= ram_s1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    task automatic do_reset();
        nxt(); reset = 1'b1; req = '0;
        nxt(); nxt(); reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[8'h10] = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = '0; req_wdata[i] = '0; zaddr[i] = '0; zdata[i] = '0;
        end

        // Reset state, with requests pending to show gnt is masked
        nxt(); reset = 1'b1; req = 4'hF;
        nxt(); smp();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_b16", 32'(b16), 32'h0);
        chk("rst_addr", 32'(addr_h), 32'h0);
        chk("rst_din", 32'(din_h), 32'h0);
        chk("rst_rdv", 32'(rd_valid), 32'h0);
        chk("rst_rdd", 32'(rd_data), 32'h0);
        nxt(); req = '0; reset = 1'b0;

        // 1: single read of 0x00010 by requester 0
        req = 4'b0001; req_wr = '0; req_addr[0] = 20'h00010;
        smp(); chk("t1_gnt", 32'(gnt), 32'h1);
        nxt(); req = '0; smp(); chk("t1_addr", 32'(addr_h), 32'h10);
        nxt(); nxt(); smp(); chk("t1_rdv_early", 32'(rd_valid), 32'h0);
        nxt(); smp();
        chk("t1_rdv", 32'(rd_valid), 32'h1);
        chk("t1_rdd", 32'(rd_data), 32'hBEEF);

        // 2: all four requesting reads continuously from ptr=0
        do_reset();
        for (int i = 0; i < 4; i++) req_addr[i] = 20'h40 + 20'(i);
        for (int c = 0; c < 13; c++) begin
            if (c > 0) nxt();
            req = (c < 8) ? 4'hF : 4'h0;
            smp();
            chk("t2_gnt", 32'(gnt), (c < 8) ? (32'(1) << (c % 4)) : 32'h0);
            if (c >= 4) begin
                chk("t2_rdv", 32'(rd_valid), (c < 12) ? (32'(1) << ((c - 4) % 4)) : 32'h0);
                if (c < 12) chk("t2_rdd", 32'(rd_data), 32'h1040 + 32'((c - 4) % 4));
            end
        end

        // 3: req1 writes 0x1234 (16-bit) to 0x20, next clk req2 reads 0x20
        nxt();
        req = 4'b0010; req_wr = 4'b0010; req_16bit = 4'b0010;
        req_addr[1] = 20'h20; req_wdata[1] = 16'h1234;
        smp(); chk("t3_gnt_wr", 32'(gnt), 32'h2);
        nxt();
        req = 4'b0100; req_wr = '0; req_16bit = '0; req_addr[2] = 20'h20;
        smp();
        chk("t3_gnt_rd", 32'(gnt), 32'h4);
        chk("t3_we", 32'(we), 32'h1);
        chk("t3_b16", 32'(b16), 32'h1);
        chk("t3_addr", 32'(addr_h), 32'h20);
        chk("t3_din", 32'(din_h), 32'h1234);
        nxt(); req = '0; smp(); chk("t3_we_off", 32'(we), 32'h0);
        nxt(); nxt(); smp(); chk("t3_rdv_early", 32'(rd_valid), 32'h0);
        nxt(); smp();
        chk("t3_rdv", 32'(rd_valid), 32'h4);
        chk("t3_rdd", 32'(rd_data), 32'h1234);
        nxt(); smp();
        chk("t3_rdv_off", 32'(rd_valid), 32'h0);
        chk("t3_rdd_hold", 32'(rd_data), 32'h1234);

        // 4: req3 8-bit write of 0x00AB
        nxt();
        req = 4'b1000; req_wr = 4'b1000; req_16bit = '0;
        req_addr[3] = 20'h30; req_wdata[3] = 16'h00AB;
        smp(); chk("t4_gnt", 32'(gnt), 32'h8);
        nxt(); req = '0; req_wr = '0; smp();
        chk("t4_we", 32'(we), 32'h1);
        chk("t4_b16", 32'(b16), 32'h0);
        chk("t4_din", 32'(din_h), 32'h00AB);
        nxt(); smp();
        chk("t4_we_off", 32'(we), 32'h0);
        chk("t4_addr_hold", 32'(addr_h), 32'h30);

        // Out-of-window read: RAM returns 0, read still completes
        nxt();
        req = 4'b0001; req_addr[0] = 20'h80000;
        smp(); chk("oow_gnt", 32'(gnt), 32'h1);
        nxt(); req = '0;
        nxt(); nxt(); smp(); chk("oow_rdd_before", 32'(rd_data), 32'h1234);
        nxt(); smp();
        chk("oow_rdv", 32'(rd_valid), 32'h1);
        chk("oow_rdd", 32'(rd_data), 32'h0);

        // 5: reset with three reads in flight
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 20'h40 + 20'(i); req_wdata[i] = 16'h5555;
        end
        req = 4'hF;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) nxt();
            smp(); chk("t5_gnt", 32'(gnt), 32'(1) << c);
        end
        nxt(); req = '0;
        nxt(); reset = 1'b1; req = 4'hF;
        smp();
        chk("t5_gnt_rst", 32'(gnt), 32'h0);
        chk("t5_rdv_pre", 32'(rd_valid), 32'h1);
        nxt(); reset = 1'b0; req = '0; smp();
        chk("t5_we", 32'(we), 32'h0);
        chk("t5_addr", 32'(addr_h), 32'h0);
        chk("t5_din", 32'(din_h), 32'h0);
        chk("t5_rdd", 32'(rd_data), 32'h0);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) nxt();
            smp(); chk("t5_rdv_quiet", 32'(rd_valid), 32'h0);
        end
        nxt(); req = 4'hF; smp(); chk("t5_ptr0", 32'(gnt), 32'h1);
        nxt(); req = '0;

        // 6: fixed priority, req=1010 held
        reqf = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            nxt(); smp(); chk("t6_gntf", 32'(gntf), 32'h2);
        end
        reqf = 4'b1000; smp(); chk("t6_gntf_only3", 32'(gntf), 32'h8);
        nxt(); reqf = '0; smp(); chk("t6_gntf_idle", 32'(gntf), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
